pipe_trace_capture: RTL



---
 rtl/pipe_trace_capture_pkg.sv | 15 +
 rtl/pipe_trace_capture_trigger.sv | 32 +++
 rtl/pipe_trace_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_trace_capture_pkg.sv
// Shared types for the pipeline trace capture block: capture state encoding
// and timestamp width.
package pipe_trace_capture_pkg;

  localparam int TS_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    POSTTRIG,
    DONE,
    READOUT
  } state_e;

endpackage

// File: rtl/pipe_trace_capture_trigger.sv
// Combinational trigger qualifier: external trigger or a value match on one
// selected probe channel, both gated by the sample qualifier.
module trace_trigger #(
  parameter  int NUM_CH = 4,
  parameter  int CH_W   = 32,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH*CH_W-1:0] probe_data_i,
  input  logic                   probe_valid_i,
  input  logic                   trig_in_i,
  input  logic                   trig_match_en_i,
  input  logic [SEL_W-1:0]       trig_ch_i,
  input  logic [CH_W-1:0]        trig_value_i,
  output logic                   trig_o
);

  logic match;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_ch_i == SEL_W'(k) && probe_data_i[k*CH_W +: CH_W] == trig_value_i) begin
        match = 1'b1;
      end
    end
  end

  assign trig_o = probe_valid_i & (trig_in_i | (trig_match_en_i & match));

endmodule

// File: rtl/pipe_trace_capture.sv
// Triggered multi-channel trace buffer with oldest-first valid/ready readout.
// Define TRACE_TIMESTAMP_EN to store a 16-bit cycle timestamp per entry.
module pipe_trace_capture
  import pipe_trace_capture_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int CH_W      = 32,
  parameter  int DEPTH     = 16,
  parameter  int POST_TRIG = 8,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DATA_W    = NUM_CH * CH_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic [DATA_W-1:0] probe_data,
  input  logic              probe_valid,
  input  logic              arm,
  input  logic              trig_in,
  input  logic              trig_match_en,
  input  logic [SEL_W-1:0]  trig_ch,
  input  logic [CH_W-1:0]   trig_value,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [TS_W-1:0]   rd_ts,
  output logic              rd_last,
  output logic              capturing,
  output logic              done,
  output logic              wrapped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;

  state_e            state_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, rd_left_q;
  logic [PC_W-1:0]   post_cnt_q;
  logic              wrapped_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic trig, wr_en, arm_take, post_last;

  trace_trigger #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_trigger (
    .probe_data_i    (probe_data),
    .probe_valid_i   (probe_valid),
    .trig_in_i       (trig_in),
    .trig_match_en_i (trig_match_en),
    .trig_ch_i       (trig_ch),
    .trig_value_i    (trig_value),
    .trig_o          (trig)
  );

  assign wr_en     = probe_valid && (state_q == PRETRIG || state_q == POSTTRIG);
  assign arm_take  = arm && (state_q == IDLE || state_q == DONE);
  assign post_last = (post_cnt_q == PC_W'(POST_TRIG - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_left_q  <= '0;
      post_cnt_q <= '0;
      wrapped_q  <= 1'b0;
    end else if (arm_take) begin
      state_q    <= PRETRIG;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      post_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q == CNT_W'(DEPTH)) wrapped_q <= 1'b1;
        else                          count_q   <= count_q + 1'b1;
      end
      unique case (state_q)
        PRETRIG: begin
          if (trig) begin
            post_cnt_q <= '0;
            state_q    <= (POST_TRIG == 0) ? DONE : POSTTRIG;
          end
        end
        POSTTRIG: begin
          if (probe_valid) begin
            post_cnt_q <= post_cnt_q + 1'b1;
            if (post_last) state_q <= DONE;
          end
        end
        DONE: begin
          if (rd_start) begin
            state_q   <= READOUT;
            rd_ptr_q  <= wrapped_q ? wr_ptr_q : '0;
            rd_left_q <= count_q;
          end
        end
        READOUT: begin
          if (rd_ready) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_left_q <= rd_left_q - 1'b1;
            if (rd_left_q == CNT_W'(1)) state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the sample array is deliberately left out of reset; only the
  // pointers and counters define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= probe_data;
  end

  assign rd_valid  = (state_q == READOUT);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign rd_last   = rd_valid && (rd_left_q == CNT_W'(1));
  assign capturing = (state_q == PRETRIG) || (state_q == POSTTRIG);
  assign done      = (state_q == DONE);
  assign wrapped   = wrapped_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!ctrl_reset) ts_q <= '0;
    else             ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_en) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  assign rd_ts = rd_valid ? ts_mem_q[rd_ptr_q] : '0;
`else
  assign rd_ts = '0;
`endif

endmodule
